fetch_stage: RTL and testbench

//  Pipelined instruction-fetch stage for the MIPS-32 core: owns the PC, issues word reads to instruction memory over a
//  req/ready handshake, and delivers {instr, pc, pc+4} to decode over a valid/ready handshake.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_skid_buffer.sv | 57 +++++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// fetch word size and the value the output register holds out of reset.
package fetch_stage_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake bundle around the fetch stage: instruction-memory request port,
// redirect input from execute and the valid/ready port towards decode.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_rdata;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_ready, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_ready, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding slot that catches a memory response arriving
// while the decode-facing output register is still occupied.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din_instr,
  input  logic [ADDR_W-1:0] din_pc,
  output logic              full,
  output logic [DATA_W-1:0] dout_instr,
  output logic [ADDR_W-1:0] dout_pc
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d  = 1'b1;
      instr_d = din_instr;
      pc_d    = din_pc;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  // NOTE: the payload is only ever read while full_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

  assign full       = full_q;
  assign dout_instr = instr_q;
  assign dout_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS-32 instruction-fetch stage: owns the PC, issues word reads and hands
// {instr, pc, pc+4} to decode. Optional FETCH_PERF_EN adds fetch/stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [ADDR_W-1:0] out_pc4_q, out_pc4_d;

  logic              skid_full, skid_push, skid_pop, skid_flush;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;

  logic req, xfer, fire, out_free;

  // A DRAIN keeps re-presenting the abandoned address until memory completes it.
  assign req      = !rst && ((state_q == ST_DRAIN) || !skid_full);
  assign xfer     = req && bus.imem_ready;
  assign fire     = out_valid_q && bus.id_ready;
  assign out_free = !out_valid_q || fire;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = (state_q == ST_DRAIN) ? hold_addr_q : pc_q;
  assign bus.id_valid    = out_valid_q;
  assign bus.id_instr    = out_instr_q;
  assign bus.id_pc       = out_pc_q;
  assign bus.id_pc_plus4 = out_pc4_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_addr_d = hold_addr_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_pc4_d   = out_pc4_q;
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
    skid_flush  = 1'b0;

    if (bus.redirect_valid) begin
      // Redirect wins over everything; an unfinished request forces a drain.
      pc_d        = bus.redirect_pc & ALIGN_MASK;
      out_valid_d = 1'b0;
      skid_flush  = 1'b1;
      hold_addr_d = bus.imem_addr;
      state_d     = (req && !bus.imem_ready) ? ST_DRAIN : ST_RUN;
    end else if (state_q == ST_DRAIN) begin
      if (bus.imem_ready) state_d = ST_RUN;
    end else begin
      if (xfer) pc_d = pc_q + STEP;
      if (out_free) begin
        if (skid_full) begin
          skid_pop    = 1'b1;
          out_valid_d = 1'b1;
          out_instr_d = skid_instr;
          out_pc_d    = skid_pc;
          out_pc4_d   = skid_pc + STEP;
        end else if (xfer) begin
          out_valid_d = 1'b1;
          out_instr_d = bus.imem_rdata;
          out_pc_d    = pc_q;
          out_pc4_d   = pc_q + STEP;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (xfer) begin
        skid_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      hold_addr_q <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= DATA_W'(NOP_INSTR);
      out_pc_q    <= '0;
      out_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_pc4_q   <= out_pc4_d;
    end
  end

  fetch_skid_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (skid_push),
    .pop        (skid_pop),
    .flush      (skid_flush),
    .din_instr  (bus.imem_rdata),
    .din_pc     (pc_q),
    .full       (skid_full),
    .dout_instr (skid_instr),
    .dout_pc    (skid_pc)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(fire);
    stall_cnt_d = stall_cnt_q + 32'(out_valid_q && !bus.id_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// memory/decode/redirect traffic, all checked against a queue-based model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  fetch_stage #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_if.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory returns a garbage word whenever it is not completing a transfer.
  assign bus_if.imem_rdata = bus_if.imem_ready ? mem_word(bus_if.imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the decode-side stream is simply the ordered list of
  // accepted (non-discarded) memory words; a redirect throws the list away.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] m_pc;
  bit          m_drain;
  bit          prev_wait;
  logic [31:0] prev_addr;
  bit          prev_stall;
  item_t       prev_out;
  int unsigned m_fetch, m_stall;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_pc       = RESET_PC;
      m_drain    = 1'b0;
      prev_wait  = 1'b0;
      prev_stall = 1'b0;
      m_fetch    = 0;
      m_stall    = 0;
    end else begin
      item_t got;
      bit    req, rdy, idv, idr, rv;
      req = bus_if.imem_req;
      rdy = bus_if.imem_ready;
      idv = bus_if.id_valid;
      idr = bus_if.id_ready;
      rv  = bus_if.redirect_valid;
      got = '{pc: bus_if.id_pc, instr: bus_if.id_instr};

      check("id_valid", 32'(idv), 32'(exp_q.size() != 0));
      check("imem_req", 32'(req), 32'(m_drain || exp_q.size() < 2));
      if (req && !m_drain) check("imem_addr", bus_if.imem_addr, m_pc);
      if (prev_wait) check("addr_hold", bus_if.imem_addr, prev_addr);
      if (prev_stall) begin
        check("stall_pc", got.pc, prev_out.pc);
        check("stall_instr", got.instr, prev_out.instr);
      end

      if (idv && idr) begin
        m_fetch++;
        if (exp_q.size() == 0) begin
          check("unexpected_item", got.pc, 32'hFFFF_FFFF);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          check("id_pc", got.pc, e.pc);
          check("id_instr", got.instr, e.instr);
          check("id_pc_plus4", bus_if.id_pc_plus4, e.pc + 32'd4);
        end
      end
      if (idv && !idr) m_stall++;

      prev_stall = idv && !idr && !rv;
      prev_out   = got;
      prev_wait  = req && !rdy;
      prev_addr  = bus_if.imem_addr;

      if (rv) begin
        exp_q.delete();
        m_pc    = bus_if.redirect_pc & ~32'd3;
        m_drain = req && !rdy;
      end else if (req && rdy) begin
        if (m_drain) begin
          m_drain = 1'b0;
        end else begin
          exp_q.push_back('{pc: bus_if.imem_addr, instr: mem_word(bus_if.imem_addr)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic cyc(input bit rdy, input bit idr, input bit rv = 1'b0,
                     input logic [31:0] tgt = 32'h0);
    bus_if.imem_ready     = rdy;
    bus_if.id_ready       = idr;
    bus_if.redirect_valid = rv;
    bus_if.redirect_pc    = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.imem_ready     = 1'b1;
    bus_if.id_ready       = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", 32'(bus_if.imem_req), 32'd0);
    check("rst_id_valid", 32'(bus_if.id_valid), 32'd0);
    check("rst_id_instr", bus_if.id_instr, 32'd0);
    check("rst_id_pc", bus_if.id_pc, 32'd0);
    check("rst_id_pc_plus4", bus_if.id_pc_plus4, 32'd0);

    rst = 1'b0;
    #1;
    check("first_req", 32'(bus_if.imem_req), 32'd1);
    check("first_addr", bus_if.imem_addr, RESET_PC);

    repeat (2) cyc(1, 1);                  // back-to-back 0x0, 0x4
    repeat (2) cyc(0, 1);                  // memory wait on 0x8
    repeat (2) cyc(1, 1);
    repeat (3) cyc(1, 0);                  // decode stall fills skid
    repeat (4) cyc(1, 1);
    cyc(0, 1, 1, 32'h0000_0040);           // redirect while pending -> drain
    cyc(0, 1);
    repeat (4) cyc(1, 1);
    cyc(1, 1, 1, 32'h0000_0043);           // redirect on transfer -> no drain
    repeat (3) cyc(1, 1);
    cyc(1, 1, 1, 32'hFFFF_FFF8);           // PC wrap-around
    repeat (4) cyc(1, 1);

    repeat (2) cyc(0, 1);                  // async reset mid-wait
    #1 rst = 1'b1;
    #1;
    check("rstpulse_imem_req", 32'(bus_if.imem_req), 32'd0);
    check("rstpulse_id_valid", 32'(bus_if.id_valid), 32'd0);
    #1 rst = 1'b0;

    repeat (6) cyc(1, 1);                  // 5 accepts
    repeat (3) cyc(0, 0);                  // 3 stall cycles
`ifdef FETCH_PERF_EN
    check("perf_fetch_5", perf_fetch_cnt, 32'd5);
    check("perf_stall_3", perf_stall_cnt, 32'd3);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 511));
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75,
          $urandom_range(0, 99) < 6, tgt);
    end

`ifdef FETCH_PERF_EN
    check("perf_fetch_total", perf_fetch_cnt, 32'(m_fetch));
    check("perf_stall_total", perf_stall_cnt, 32'(m_stall));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
